writeback: RTL



---
 rtl/writeback.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/writeback.sv
// Writeback stage: retires ALU results in one cycle and loads after a memory read response
// (with timeout). Optional little-endian sub-word load extraction via `LOAD_EXT_EN.
module writeback #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 5,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_reg_write,
   input  logic             in_mem_to_reg,
   input  logic [DEPTH-1:0] in_wr,
   input  logic [WIDTH-1:0] in_alu_result,
   input  logic [1:0]       in_byte_addr,
   input  logic [1:0]       in_load_size,
   input  logic             in_load_signed,
   input  logic             mem_rvalid,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             RegWrite,
   output logic [DEPTH-1:0] WR,
   output logic [WIDTH-1:0] WD,
   output logic             load_timeout,
   output logic             dbg_state
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

   state_t           r_state, w_state_next;
   logic [CW-1:0]    r_cnt, w_cnt_next;
   logic             r_reg_write;
   logic [DEPTH-1:0] r_wr;
   logic             w_latch, w_we, w_timeout;
   logic [DEPTH-1:0] w_wr;
   logic [WIDTH-1:0] w_wd, w_load_data;

   // Handshake: an instruction is taken on a posedge where in_valid && in_ready; in_ready
   // depends only on state, so it never combinationally depends on in_valid.
   assign in_ready  = (r_state == IDLE);
   assign dbg_state = r_state;

`ifdef LOAD_EXT_EN
   logic [1:0] r_byte_addr, r_load_size;
   logic       r_load_signed;
   logic [7:0] w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = mem_rdata[{r_byte_addr, 3'b000} +: 8];
      w_half = mem_rdata[{r_byte_addr[1], 4'b0000} +: 16];
      case (r_load_size)
         2'd0:    w_load_data = {{(WIDTH-8){r_load_signed & w_byte[7]}}, w_byte};
         2'd1:    w_load_data = {{(WIDTH-16){r_load_signed & w_half[15]}}, w_half};
         default: w_load_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_byte_addr   <= '0;
         r_load_size   <= '0;
         r_load_signed <= 1'b0;
      end else if (w_latch) begin
         r_byte_addr   <= in_byte_addr;
         r_load_size   <= in_load_size;
         r_load_signed <= in_load_signed;
      end
   end
`else
   logic w_unused;
   assign w_unused    = ^{in_byte_addr, in_load_size, in_load_signed};
   assign w_load_data = mem_rdata;
`endif

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_latch      = 1'b0;
      w_we         = 1'b0;
      w_timeout    = 1'b0;
      w_wr         = WR;
      w_wd         = WD;
      case (r_state)
         IDLE: begin
            // mem_rvalid is deliberately not looked at here: stray responses are dropped.
            if (in_valid) begin
               if (in_mem_to_reg) begin
                  w_latch      = 1'b1;
                  w_cnt_next   = '0;
                  w_state_next = WAIT_MEM;
               end else begin
                  w_we = in_reg_write && (in_wr != '0);
                  w_wr = in_wr;
                  w_wd = in_alu_result;
               end
            end
         end
         WAIT_MEM: begin
            if (mem_rvalid) begin
               w_we         = r_reg_write && (r_wr != '0);
               w_wr         = r_wr;
               w_wd         = w_load_data;
               w_state_next = IDLE;
            end else if (r_cnt == CW'(TIMEOUT - 1)) begin
               w_timeout    = 1'b1;
               w_state_next = IDLE;
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_reg_write  <= 1'b0;
         r_wr         <= '0;
         RegWrite     <= 1'b0;
         WR           <= '0;
         WD           <= '0;
         load_timeout <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_cnt    <= w_cnt_next;
         RegWrite <= w_we;
         // WR/WD only move on an actual write so they stay a stable forwarding source.
         if (w_we) begin
            WR <= w_wr;
            WD <= w_wd;
         end
         if (w_timeout) load_timeout <= 1'b1;
         if (w_latch) begin
            r_reg_write <= in_reg_write;
            r_wr        <= in_wr;
         end
      end
   end

endmodule
